// File: rtl/counter_seq_pkg.sv
// Shared types for the count sequencer: controller states and the
// control bundle that drives the up/down counter datapath.
package counter_seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic clr;
        logic load;
        logic en;
        logic up;
    } ctr_ctrl_t;

endpackage

// File: rtl/ud_counter.sv
// N-bit loadable up/down counter with modulo-2^N wrap.
// Priority: reset, clear, load, enable; holds otherwise.
module ud_counter
    import counter_seq_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  ctr_ctrl_t    ctrl,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ctrl.clr) begin
            q <= '0;
        end else if (ctrl.load) begin
            q <= d;
        end else if (ctrl.en) begin
            q <= ctrl.up ? q + N'(1) : q - N'(1);
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Runs programmed count sequences on a ud_counter: load start value,
// step toward the end value, pulse done, optionally reload and repeat.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] start_val,
    input  logic [N-1:0] end_val,
    input  logic         up,
    input  logic         reload,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] cnt
);

    seq_state_t   state, state_nxt;
    ctr_ctrl_t    ctrl;
    logic         latch;
    logic [N-1:0] start_r, end_r;
    logic         up_r, reload_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            start_r  <= '0;
            end_r    <= '0;
            up_r     <= 1'b0;
            reload_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                start_r  <= start_val;
                end_r    <= end_val;
                up_r     <= up;
                reload_r <= reload;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ctrl      = '0;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    latch     = 1'b1;
                end
            end
            LOAD: begin
                ctrl.load = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (cnt == end_r) begin
                    state_nxt = DONE;
                end else begin
                    ctrl.en = 1'b1;
                end
            end
            DONE: begin
                state_nxt = reload_r ? LOAD : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        ctrl.up = up_r;
        // abort overrides everything, including a start seen in IDLE
        if (abort) begin
            ctrl      = '0;
            ctrl.clr  = 1'b1;
            state_nxt = IDLE;
            latch     = 1'b0;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    ud_counter #(.N(N)) u_ctr (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ctrl),
        .d    (start_r),
        .q    (cnt)
    );

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed vector table,
// hand-written corner sequences and random traffic against a queue-based model.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, abort, up, reload;
    logic [7:0] start_val, end_val;
    logic       busy, done;
    logic [7:0] cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    counter_sequencer #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .start_val (start_val),
        .end_val   (end_val),
        .up        (up),
        .reload    (reload),
        .busy      (busy),
        .done      (done),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start expands into the list of
    // per-cycle observations it will produce; abort/reset flush it.
    typedef struct {
        logic [7:0] cnt;
        bit         busy;
        bit         done;
        bit         regen;
    } obs_t;

    obs_t       exp_q[$];
    obs_t       cur = '{8'd0, 1'b0, 1'b0, 1'b0};
    logic [7:0] m_s, m_e;
    bit         m_up, m_rl;

    function automatic void expand();
        logic [7:0] steps;
        steps = m_up ? (m_e - m_s) : (m_s - m_e);
        for (int k = 0; k <= int'(steps); k++)
            exp_q.push_back('{m_up ? m_s + 8'(k) : m_s - 8'(k), 1'b1, 1'b0, 1'b0});
        exp_q.push_back('{m_e, 1'b1, 1'b1, 1'b0});
        exp_q.push_back('{m_e, m_rl, 1'b0, m_rl});
    endfunction

    always @(posedge clk) begin
        if (rst || abort) begin
            exp_q.delete();
            cur = '{8'd0, 1'b0, 1'b0, 1'b0};
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            if (cur.regen) expand();
        end else begin
            cur.done = 1'b0;
            cur.busy = 1'b0;
            if (start) begin
                m_s = start_val; m_e = end_val; m_up = up; m_rl = reload;
                cur.busy = 1'b1;
                expand();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_cnt", int'(cnt), int'(cur.cnt));
            check("model_busy", int'(busy), int'(cur.busy));
            check("model_done", int'(done), int'(cur.done));
        end
    end

    typedef struct {
        logic [7:0] sv;
        logic [7:0] ev;
        logic       dir;
        int         lat;
        logic [7:0] cnt_at_done;
    } vec_t;

    vec_t vecs[5];

    task automatic wait_idle();
        for (int i = 0; i < 600; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        check("idle_timeout", 1, 0);
    endtask

    int k, n;

    initial begin
        vecs[0] = '{8'd3,   8'd7,   1'b1, 6,  8'd7};
        vecs[1] = '{8'd2,   8'd254, 1'b0, 6,  8'd254};
        vecs[2] = '{8'd5,   8'd5,   1'b1, 2,  8'd5};
        vecs[3] = '{8'd250, 8'd3,   1'b1, 11, 8'd3};
        vecs[4] = '{8'd0,   8'd255, 1'b0, 3,  8'd255};

        rst = 1'b1; start = 1'b0; abort = 1'b0; up = 1'b0; reload = 1'b0;
        start_val = '0; end_val = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_cnt", int'(cnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table: latency to done, final count, busy falls after done.
        for (int i = 0; i < 5; i++) begin
            wait_idle();
            start_val = vecs[i].sv; end_val = vecs[i].ev;
            up = vecs[i].dir; reload = 1'b0; start = 1'b1;
            @(negedge clk);
            start_val = 8'($urandom); end_val = 8'($urandom);
            up = 1'($urandom); reload = 1'b1;
            k = 0;
            while (k <= 300) begin
                @(negedge clk);
                k++;
                start = 1'b0;
                if (done) break;
            end
            reload = 1'b0;
            check("vec_latency", k, vecs[i].lat);
            check("vec_cnt_at_done", int'(cnt), int'(vecs[i].cnt_at_done));
            @(negedge clk);
            check("vec_busy_fall", int'(busy), 0);
            check("vec_done_single", int'(done), 0);
        end

        // Reset held for two cycles mid-RUN, with start asserted.
        wait_idle();
        start_val = 8'd0; end_val = 8'd200; up = 1'b1; reload = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_cnt", int'(cnt), 0);
            check("midrst_busy", int'(busy), 0);
            check("midrst_done", int'(done), 0);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("postrst_busy", int'(busy), 0);

        // Reload mode, then abort mid-RUN.
        start_val = 8'd0; end_val = 8'd2; up = 1'b1; reload = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; reload = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) n++;
        end
        check("reload_done_count", n, 2);
        check("reload_cnt_phase", int'(cnt), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_cnt", int'(cnt), 0);
        check("abort_busy", int'(busy), 0);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) n++;
        end
        check("abort_no_done", n, 0);

        // abort and start together in IDLE: start dropped.
        start_val = 8'd9; end_val = 8'd12; up = 1'b1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", int'(busy), 0);
        check("abort_start_cnt", int'(cnt), 0);
        repeat (2) @(negedge clk);
        check("abort_start_idle", int'(busy), 0);

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(199) == 0);
            abort = ($urandom_range(39) == 0);
            start = ($urandom_range(2) == 0);
            up    = 1'($urandom);
            reload = ($urandom_range(3) == 0);
            start_val = 8'($urandom);
            if ($urandom_range(7) == 0)
                end_val = 8'($urandom);
            else
                end_val = up ? start_val + 8'($urandom_range(11))
                             : start_val - 8'($urandom_range(11));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
